regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
- Shares the single register-file write port between two sources:
  - the pipeline write-back stage (mux output of the WB stage);
  - a secondary requester (debug unit / multi-cycle unit results).
- Pipeline WB always has priority. Secondary writes are buffered in a 2-entry FIFO and drained in free WB slots.
- A starvation guard requests a one-cycle pipeline bubble from the hazard unit.
- Sits between the WB stage and the register file; the write port to the regfile is registered.

Parameters:
- NB_BITS, 32, data width of register writes
- NB_ADDR, 5, register address width
- MAX_WAIT, 8, cycles a FIFO head may wait before a stall is requested (>=1)

Ports:
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_wb_we  input  1  pipeline WB write enable
- i_wb_addr  input  NB_ADDR  pipeline WB destination register
- i_wb_data  input  NB_BITS  pipeline WB data (mem/alu mux output)
- i_sec_valid  input  1  secondary write request valid
- i_sec_addr  input  NB_ADDR  secondary destination register
- i_sec_data  input  NB_BITS  secondary data
- o_sec_ready  output  1  FIFO can accept (not full)
- o_rf_we  output  1  registered regfile write enable
- o_rf_addr  output  NB_ADDR  registered regfile address
- o_rf_data  output  NB_BITS  registered regfile data
- o_stall_req  output  1  request a WB bubble (hazard unit forces i_wb_we=0 next cycle)
- o_pend_valid  output  1  FIFO non-empty
- o_pend_addr  output  NB_ADDR  address of FIFO head (for hazard detection)

Behaviour:
- Reset is asynchronous, active-low, single clock i_clk. While i_rst_n=0, all of the following are 0: o_rf_we, o_rf_addr, o_rf_data, o_stall_req, o_pend_valid, o_pend_addr, FIFO pointers/count, wait counter. FSM goes to IDLE.
- Reset mid-operation discards buffered entries; no partial write escapes.
- o_sec_ready = (count < 2), combinational from registered count. A secondary write is accepted on a rising edge when i_sec_valid && o_sec_ready.
- FIFO depth is 2 with wrap-around pointers. A simultaneous push and pop at count=2 is not possible because ready=0. At count=1, push+pop leaves count=1.
- Write slot selection, each cycle:
  - If i_wb_we=1 and i_wb_addr!=0: the pipeline write wins.
  - Else if the FIFO is non-empty and the head address !=0: pop the head and write it.
  - Else: no write.
- Entries with address 0 are popped silently and never written. A pipeline write to address 0 is treated as a free slot.
- The selected write appears on o_rf_* one cycle later (latency 1). o_rf_addr/o_rf_data hold their last value when o_rf_we=0.
- Two writes in one cycle are never possible.
- FSM states:
  - IDLE: FIFO empty, wait counter 0. Goes to WAIT on a push.
  - WAIT: head pending; wait counter increments every cycle the head is not popped.
    - Head popped and FIFO becomes empty: go to IDLE.
    - Head popped, another entry remains: stay in WAIT with the counter cleared.
    - Counter reaches MAX_WAIT-1 without a pop: go to STALL.
  - STALL: o_stall_req=1 (registered; asserted the cycle STALL is entered).
    - The head is popped in the first cycle with a free slot (i_wb_we=0 or addr 0). Then clear the counter, deassert o_stall_req, and go to WAIT or IDLE by FIFO state.
    - o_stall_req stays high until that pop.
- o_pend_valid / o_pend_addr reflect the registered FIFO state (head entry). The hazard unit uses them for RAW checks; this block does no ordering reconciliation between sources.
- No arithmetic beyond the pointer/counter increments. The counter is $clog2(MAX_WAIT)+1 bits and saturates.

Decomposition:
- Shared package/include:
  - FSM state encodings ARB_IDLE=2'd0, ARB_WAIT=2'd1, ARB_STALL=2'd2;
  - REG_ZERO=5'd0;
  - DATA_FROM_MEM / DATA_FROM_ALU remain there unchanged.
- One natural sub-module: wr_req_fifo, a 2-entry (parameterised depth) valid/ready FIFO of {addr,data} with count, full and empty.
- The arbiter FSM and output register live in the top.

Test Plan:
- Reset: i_rst_n=0 mid-stream with 2 entries queued -> all outputs 0 immediately (async), o_sec_ready=1 after release, no write of the queued data.
- Pipeline only: i_wb_we=1, addr=5'd3, data=32'hDEADBEEF -> next cycle o_rf_we=1, o_rf_addr=3, o_rf_data=32'hDEADBEEF.
- Free-slot drain: push sec (addr 7, 32'h1234) with i_wb_we=0 -> the cycle after the push, the arbiter drives o_rf_we=1, addr 7; o_pend_valid returns to 0.
- Full FIFO: push 2 entries while i_wb_we=1 on addr 4 continuously -> o_sec_ready=0, a third request is held; same-cycle push+pop at count 1 keeps count 1.
- Starvation: one entry queued, i_wb_we=1 for 20 cycles, MAX_WAIT=8 -> o_stall_req rises 8 cycles after the push. Drop i_wb_we the next cycle -> entry written, o_stall_req falls.
- Register 0: pipeline write to addr 0 plus a queued sec entry -> the sec entry is written that slot. A sec entry with addr 0 is popped with o_rf_we=0.

Source files
------------

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter.
//   arb_state_e   : arbiter FSM states (idle / head waiting / stall requested)
//   REG_ZERO      : hard-wired zero register, never written
//   DATA_FROM_*   : WB-stage data mux selects used elsewhere in the pipeline
package regfile_wr_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_WAIT  = 2'd1,
        ARB_STALL = 2'd2
    } arb_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic DATA_FROM_MEM = 1'b0;
    localparam logic DATA_FROM_ALU = 1'b1;

endpackage

// File: rtl/regfile_wr_arbiter_wr_req_fifo.sv
// Small valid/ready FIFO of pending register writes {addr, data}.
//   i_clk, i_rst_n           : clock, asynchronous active-low reset
//   i_push, i_push_addr/data : enqueue (ignored while full)
//   i_pop                    : dequeue head (ignored while empty)
//   o_head_addr/data         : current head entry (valid when !o_empty)
//   o_count, o_full, o_empty : occupancy, all from registered state
module wr_req_fifo #(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned NB_ADDR = 5,
    parameter int unsigned NB_BITS = 32,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_push,
    input  logic [NB_ADDR-1:0] i_push_addr,
    input  logic [NB_BITS-1:0] i_push_data,
    input  logic               i_pop,
    output logic [NB_ADDR-1:0] o_head_addr,
    output logic [NB_BITS-1:0] o_head_data,
    output logic [CNT_W-1:0]   o_count,
    output logic               o_full,
    output logic               o_empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NB_ADDR-1:0] mem_addr [DEPTH];
    logic [NB_BITS-1:0] mem_data [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    // Pointers wrap explicitly so non-power-of-two depths also work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_full  = (count == CNT_W'(DEPTH));
    assign o_empty = (count == '0);
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_addr[i] <= '0;
                mem_data[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_addr[wr_ptr] <= i_push_addr;
                mem_data[wr_ptr] <= i_push_data;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign o_head_addr = mem_addr[rd_ptr];
    assign o_head_data = mem_data[rd_ptr];
    assign o_count     = count;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the single register-file write port between the pipeline WB
// stage (always wins) and a secondary requester buffered in a 2-entry FIFO.
// A head entry that waits too long raises a stall request so the hazard
// unit inserts a WB bubble in which the entry drains.
//   i_clk, i_rst_n            : clock, asynchronous active-low reset
//   i_wb_we/addr/data         : pipeline write-back request
//   i_sec_valid/addr/data     : secondary write request, o_sec_ready = FIFO not full
//   o_rf_we/addr/data         : registered regfile write port (addr/data hold when idle)
//   o_stall_req               : registered request for a one-cycle WB bubble
//   o_pend_valid/o_pend_addr  : FIFO head, for hazard-unit RAW checks
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int unsigned NB_BITS  = 32,
    parameter int unsigned NB_ADDR  = 5,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_wb_we,
    input  logic [NB_ADDR-1:0] i_wb_addr,
    input  logic [NB_BITS-1:0] i_wb_data,
    input  logic               i_sec_valid,
    input  logic [NB_ADDR-1:0] i_sec_addr,
    input  logic [NB_BITS-1:0] i_sec_data,
    output logic               o_sec_ready,
    output logic               o_rf_we,
    output logic [NB_ADDR-1:0] o_rf_addr,
    output logic [NB_BITS-1:0] o_rf_data,
    output logic               o_stall_req,
    output logic               o_pend_valid,
    output logic [NB_ADDR-1:0] o_pend_addr
);

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned WAIT_W     = $clog2(MAX_WAIT) + 1;

    arb_state_e         state;
    arb_state_e         state_nxt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [WAIT_W-1:0]  wait_nxt;
    logic               stall_nxt;

    logic [NB_ADDR-1:0] head_addr;
    logic [NB_BITS-1:0] head_data;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;

    logic               push;
    logic               pop;
    logic               wb_win;
    logic               sec_wr;
    logic               fifo_drains;

    logic               rf_we_nxt;
    logic [NB_ADDR-1:0] rf_addr_nxt;
    logic [NB_BITS-1:0] rf_data_nxt;

    wr_req_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .NB_ADDR (NB_ADDR),
        .NB_BITS (NB_BITS)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (push),
        .i_push_addr (i_sec_addr),
        .i_push_data (i_sec_data),
        .i_pop       (pop),
        .o_head_addr (head_addr),
        .o_head_data (head_data),
        .o_count     (fifo_count),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty)
    );

    assign o_sec_ready  = !fifo_full;
    assign push         = i_sec_valid && o_sec_ready;

    // A WB write to the zero register does not consume the slot.
    assign wb_win       = i_wb_we && (i_wb_addr != NB_ADDR'(REG_ZERO));
    // Zero-address entries still take the free slot to pop, but never write.
    assign pop          = !fifo_empty && !wb_win;
    assign sec_wr       = pop && (head_addr != NB_ADDR'(REG_ZERO));
    assign fifo_drains  = pop && !push && (fifo_count == CNT_W'(1));

    assign o_pend_valid = !fifo_empty;
    assign o_pend_addr  = fifo_empty ? '0 : head_addr;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ARB_IDLE;
            wait_cnt    <= '0;
            o_stall_req <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_nxt;
            o_stall_req <= stall_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        unique case (state)
            ARB_IDLE: begin
                wait_nxt = '0;
                if (push) begin
                    state_nxt = ARB_WAIT;
                end
            end
            ARB_WAIT, ARB_STALL: begin
                if (pop) begin
                    wait_nxt  = '0;
                    state_nxt = fifo_drains ? ARB_IDLE : ARB_WAIT;
                end else if (state == ARB_WAIT) begin
                    wait_nxt = (wait_cnt == '1) ? wait_cnt : wait_cnt + WAIT_W'(1);
                    if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
                        state_nxt = ARB_STALL;
                    end
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
                wait_nxt  = '0;
            end
        endcase
    end

    // Output logic: stall flag and write-port selection
    always_comb begin
        stall_nxt   = (state_nxt == ARB_STALL);
        rf_we_nxt   = 1'b0;
        rf_addr_nxt = o_rf_addr;
        rf_data_nxt = o_rf_data;
        if (wb_win) begin
            rf_we_nxt   = 1'b1;
            rf_addr_nxt = i_wb_addr;
            rf_data_nxt = i_wb_data;
        end else if (sec_wr) begin
            rf_we_nxt   = 1'b1;
            rf_addr_nxt = head_addr;
            rf_data_nxt = head_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rf_we   <= 1'b0;
            o_rf_addr <= '0;
            o_rf_data <= '0;
        end else begin
            o_rf_we   <= rf_we_nxt;
            o_rf_addr <= rf_addr_nxt;
            o_rf_data <= rf_data_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;

    localparam int NB_BITS  = 32;
    localparam int NB_ADDR  = 5;
    localparam int MAX_WAIT = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               wb_we;
    logic [NB_ADDR-1:0] wb_addr;
    logic [NB_BITS-1:0] wb_data;
    logic               sec_valid;
    logic [NB_ADDR-1:0] sec_addr;
    logic [NB_BITS-1:0] sec_data;
    logic               sec_ready;
    logic               rf_we;
    logic [NB_ADDR-1:0] rf_addr;
    logic [NB_BITS-1:0] rf_data;
    logic               stall_req;
    logic               pend_valid;
    logic [NB_ADDR-1:0] pend_addr;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(
        .NB_BITS  (NB_BITS),
        .NB_ADDR  (NB_ADDR),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_wb_we      (wb_we),
        .i_wb_addr    (wb_addr),
        .i_wb_data    (wb_data),
        .i_sec_valid  (sec_valid),
        .i_sec_addr   (sec_addr),
        .i_sec_data   (sec_data),
        .o_sec_ready  (sec_ready),
        .o_rf_we      (rf_we),
        .o_rf_addr    (rf_addr),
        .o_rf_data    (rf_data),
        .o_stall_req  (stall_req),
        .o_pend_valid (pend_valid),
        .o_pend_addr  (pend_addr)
    );

    // Reference model: pending writes as a queue, plus how many edges the
    // current head has gone without being popped.
    typedef struct {
        logic [NB_ADDR-1:0] addr;
        logic [NB_BITS-1:0] data;
    } ent_t;

    ent_t               q[$];
    int                 age;
    logic               m_we;
    logic [NB_ADDR-1:0] m_addr;
    logic [NB_BITS-1:0] m_data;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        age    = 0;
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    task automatic compare_all();
        logic [NB_ADDR-1:0] exp_pend;
        exp_pend = (q.size() > 0) ? q[0].addr : '0;
        check("sec_ready",  64'(sec_ready),  64'(q.size() < 2));
        check("rf_we",      64'(rf_we),      64'(m_we));
        check("rf_addr",    64'(rf_addr),    64'(m_addr));
        check("rf_data",    64'(rf_data),    64'(m_data));
        check("stall_req",  64'(stall_req),  64'(q.size() > 0 && age >= MAX_WAIT));
        check("pend_valid", 64'(pend_valid), 64'(q.size() > 0));
        check("pend_addr",  64'(pend_addr),  64'(exp_pend));
    endtask

    // One clock: predict from the inputs currently applied, take the edge,
    // then compare every output against the prediction.
    task automatic step();
        logic wb_win, pop, push, head_wr;
        ent_t head, incoming, dummy;
        wb_win        = wb_we && (wb_addr != '0);
        pop           = (q.size() > 0) && !wb_win;
        push          = sec_valid && (q.size() < 2);
        head.addr     = '0;
        head.data     = '0;
        if (q.size() > 0) head = q[0];
        head_wr       = pop && (head.addr != '0);
        incoming.addr = sec_addr;
        incoming.data = sec_data;
        @(posedge clk);
        #1;
        if (wb_win) begin
            m_we = 1'b1; m_addr = wb_addr; m_data = wb_data;
        end else if (head_wr) begin
            m_we = 1'b1; m_addr = head.addr; m_data = head.data;
        end else begin
            m_we = 1'b0;
        end
        if (pop) begin
            dummy = q.pop_front();
            age   = 0;
        end else if (q.size() > 0) begin
            age++;
        end
        if (push) q.push_back(incoming);
        compare_all();
    endtask

    task automatic idle_inputs();
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        sec_valid = 1'b0; sec_addr = '0; sec_data = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rf_we"},      64'(rf_we),      64'(0));
        check({tag, "_rf_addr"},    64'(rf_addr),    64'(0));
        check({tag, "_rf_data"},    64'(rf_data),    64'(0));
        check({tag, "_stall"},      64'(stall_req),  64'(0));
        check({tag, "_pend_valid"}, 64'(pend_valid), 64'(0));
        check({tag, "_pend_addr"},  64'(pend_addr),  64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int rise;
        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        check("reset_sec_ready", 64'(sec_ready), 64'(1));
        rst_n = 1'b1;
        step();

        // Pipeline-only write, latency 1
        wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEADBEEF;
        step();
        check("wb_lit_we",   64'(rf_we),   64'(1));
        check("wb_lit_addr", 64'(rf_addr), 64'(3));
        check("wb_lit_data", 64'(rf_data), 64'h0000_0000_DEAD_BEEF);
        wb_we = 1'b0;

        // Secondary write drained in a free slot
        sec_valid = 1'b1; sec_addr = 5'd7; sec_data = 32'h1234;
        step();
        sec_valid = 1'b0;
        check("drain_pend_valid", 64'(pend_valid), 64'(1));
        check("drain_pend_addr",  64'(pend_addr),  64'(7));
        step();
        check("drain_we",         64'(rf_we),      64'(1));
        check("drain_addr",       64'(rf_addr),    64'(7));
        check("drain_data",       64'(rf_data),    64'h1234);
        check("drain_pend_clear", 64'(pend_valid), 64'(0));

        // Full FIFO under continuous WB traffic
        wb_we = 1'b1; wb_addr = 5'd4; wb_data = 32'hA5A5_0004;
        sec_valid = 1'b1; sec_addr = 5'd9;  sec_data = 32'h9;  step();
        sec_addr = 5'd10; sec_data = 32'hA; step();
        check("full_ready", 64'(sec_ready), 64'(0));
        sec_addr = 5'd11; sec_data = 32'hB; step();
        check("full_held_head", 64'(pend_addr), 64'(9));
        check("full_held_ready", 64'(sec_ready), 64'(0));
        wb_we = 1'b0;
        step();
        check("full_pop_addr", 64'(rf_addr), 64'(9));
        step();
        check("pushpop_addr",  64'(rf_addr),    64'(10));
        check("pushpop_pend",  64'(pend_addr),  64'(11));
        check("pushpop_valid", 64'(pend_valid), 64'(1));
        check("pushpop_ready", 64'(sec_ready),  64'(1));
        sec_valid = 1'b0;
        step();

        // Starvation: head waits behind WB writes until the stall request
        wb_we = 1'b1; wb_addr = 5'd4;
        sec_valid = 1'b1; sec_addr = 5'd12; sec_data = 32'hC0FFEE;
        step();
        sec_valid = 1'b0;
        rise = -1;
        for (int i = 1; i <= 20; i++) begin
            wb_data = 32'(i);
            step();
            if (stall_req && rise < 0) rise = i;
        end
        check("stall_rise_cycle", 64'(rise), 64'(MAX_WAIT));
        check("stall_held", 64'(stall_req), 64'(1));
        wb_we = 1'b0;
        step();
        check("stall_drain_we",   64'(rf_we),     64'(1));
        check("stall_drain_addr", 64'(rf_addr),   64'(12));
        check("stall_drain_data", 64'(rf_data),   64'h00C0_FFEE);
        check("stall_fall",       64'(stall_req), 64'(0));

        // Register 0 handling
        wb_we = 1'b1; wb_addr = 5'd4; wb_data = 32'h44;
        sec_valid = 1'b1; sec_addr = 5'd13; sec_data = 32'hD;
        step();
        sec_valid = 1'b0;
        wb_addr = 5'd0; wb_data = 32'hBAD;
        step();
        check("r0_wb_free_we",   64'(rf_we),   64'(1));
        check("r0_wb_free_addr", 64'(rf_addr), 64'(13));
        check("r0_wb_free_data", 64'(rf_data), 64'hD);
        wb_addr = 5'd4; wb_data = 32'h44;
        sec_valid = 1'b1; sec_addr = 5'd0; sec_data = 32'hBAD0;
        step();
        sec_valid = 1'b0;
        wb_we = 1'b0;
        step();
        check("r0_sec_we",   64'(rf_we),      64'(0));
        check("r0_sec_addr", 64'(rf_addr),    64'(4));
        check("r0_sec_pend", 64'(pend_valid), 64'(0));

        // Randomized traffic; the hazard unit usually honours stall requests
        for (int phase = 0; phase < 2; phase++) begin
            for (int n = 0; n < 300; n++) begin
                wb_we     = ($urandom_range(0, 99) < ((phase == 0) ? 88 : 50));
                if (stall_req && $urandom_range(0, 3) != 0) wb_we = 1'b0;
                wb_addr   = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                wb_data   = $urandom;
                sec_valid = ($urandom_range(0, 99) < 40);
                sec_addr  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                sec_data  = $urandom;
                step();
            end
        end

        // Reset mid-stream with two entries queued
        idle_inputs();
        wb_we = 1'b1; wb_addr = 5'd4; wb_data = 32'h77;
        step();
        step();
        sec_valid = 1'b1; sec_addr = 5'd20; sec_data = 32'h20; step();
        sec_addr = 5'd21; sec_data = 32'h21; step();
        check("pre_reset_full", 64'(sec_ready), 64'(0));
        sec_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wb_we = 1'b0;
        check("post_reset_ready", 64'(sec_ready), 64'(1));
        for (int n = 0; n < 4; n++) begin
            step();
            check("post_reset_no_write", 64'(rf_we), 64'(0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
